// File: rtl/high_to_low_control.sv
// rtl/high_to_low_control.sv - falling-edge path-delay controller; define HTL_TIMEOUT_EN for bounded waits
module high_to_low_control #(
    parameter int PRE_CYCLES = 4,
    parameter int CW         = 8,
    parameter int TIMEOUT    = 200
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pathResult,
    output logic          pathInput,
    output logic          ld_reg,
    output logic          fin,
    output logic          busy,
    output logic          err,
    output logic [CW-1:0] lat_cnt
);

    localparam int PW = (PRE_CYCLES > 1) ? $clog2(PRE_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRE_CYCLES - 1);
    localparam logic [CW-1:0] LAT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRECHG,
        S_WAIT_FALL,
        S_LOAD,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pre_cnt, pre_nxt;
    logic [CW-1:0] lat_nxt;

`ifdef HTL_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] tmo_cnt, tmo_nxt;
    logic          err_r, err_nxt;
    assign err = err_r;
`else
    localparam int unused_timeout = TIMEOUT;
    assign err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pre_nxt   = pre_cnt;
        lat_nxt   = lat_cnt;
`ifdef HTL_TIMEOUT_EN
        tmo_nxt   = tmo_cnt;
        err_nxt   = err_r;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_PRECHG;
                    pre_nxt   = '0;
                    lat_nxt   = '0;
`ifdef HTL_TIMEOUT_EN
                    tmo_nxt   = '0;
                    err_nxt   = 1'b0;
`endif
                end
            end
            S_PRECHG: begin
                // pre_cnt saturates at the minimum, so equality means "minimum met"
                if (pre_cnt == PRE_LAST && pathResult) begin
                    state_nxt = S_WAIT_FALL;
                end else begin
                    if (pre_cnt != PRE_LAST) pre_nxt = pre_cnt + 1'b1;
`ifdef HTL_TIMEOUT_EN
                    if (tmo_cnt == TMO_LAST) begin
                        state_nxt = S_DONE;
                        err_nxt   = 1'b1;
                    end else begin
                        tmo_nxt = tmo_cnt + 1'b1;
                    end
`endif
                end
            end
            S_WAIT_FALL: begin
                if (!pathResult) begin
                    state_nxt = S_LOAD;
                end else begin
                    if (lat_cnt != LAT_MAX) lat_nxt = lat_cnt + 1'b1;
`ifdef HTL_TIMEOUT_EN
                    if (lat_cnt == TMO_LAST) begin
                        state_nxt = S_DONE;
                        err_nxt   = 1'b1;
                    end
`endif
                end
            end
            S_LOAD:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pre_cnt   <= '0;
            lat_cnt   <= '0;
            pathInput <= 1'b0;
            ld_reg    <= 1'b0;
            fin       <= 1'b0;
            busy      <= 1'b0;
`ifdef HTL_TIMEOUT_EN
            tmo_cnt   <= '0;
            err_r     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            pre_cnt   <= pre_nxt;
            lat_cnt   <= lat_nxt;
            pathInput <= (state_nxt == S_PRECHG);
            ld_reg    <= (state_nxt == S_LOAD);
            fin       <= (state_nxt == S_DONE);
            busy      <= (state_nxt == S_PRECHG) || (state_nxt == S_WAIT_FALL) ||
                         (state_nxt == S_LOAD);
`ifdef HTL_TIMEOUT_EN
            tmo_cnt   <= tmo_nxt;
            err_r     <= err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_high_to_low_control.sv
// tb/tb_high_to_low_control.sv - randomized self-checking bench for high_to_low_control
module tb_high_to_low_control;

    localparam int PRE = 4;
    localparam int NC  = 40;
    localparam int BIG = 100000;
`ifdef HTL_TIMEOUT_EN
    localparam int TMO    = 20;
    localparam bit TMO_ON = 1'b1;
`else
    localparam int TMO    = 200;
    localparam bit TMO_ON = 1'b0;
`endif

    localparam int M_CLOSED = 0;
    localparam int M_RANDOM = 1;
    localparam int M_ONES   = 2;
    localparam int M_IMMED  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pathResult = 1'b0;
    logic       pathInput, ld_reg, fin, busy, err;
    logic [7:0] lat_cnt;

    int checks = 0;
    int passed = 0;

    high_to_low_control #(.PRE_CYCLES(PRE), .CW(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .pathResult(pathResult),
        .pathInput(pathInput), .ld_reg(ld_reg), .fin(fin), .busy(busy),
        .err(err), .lat_cnt(lat_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_idle(input string name, input int cyc);
        if ({pathInput, ld_reg, fin, busy, err} !== 5'b0 || lat_cnt !== 8'd0) begin
            $display("FAIL %s cyc%0d outputs got pi=%b ld=%b fin=%b busy=%b err=%b lat=%0d exp all 0",
                     name, cyc, pathInput, ld_reg, fin, busy, err, lat_cnt);
        end else passed++;
        checks++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_idle("reset_idle", i);
        end
    endtask

    // One measurement run from IDLE or DONE; expectations come from the timing rules afterwards.
    task automatic do_run(input int mode, input int dly, input bit mid_start, input string name);
        bit         res   [0:NC];
        bit         o_pi  [0:NC];
        bit         o_ld  [0:NC];
        bit         o_fin [0:NC];
        bit         o_busy[0:NC];
        bit         o_err [0:NC];
        logic [7:0] o_lat [0:NC];
        int p, k, ld_c, done_from, lat_cap;
        bit err_run;
        bit e_pi, e_ld, e_fin, e_busy, e_err;
        int e_lat;

        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        res[0] = 1'b0;
        o_pi[0] = 1'b0;
        for (int i = 1; i <= NC; i++) begin
            case (mode)
                M_CLOSED: res[i] = (i - dly >= 1) ? o_pi[i-dly] : 1'b0;
                M_RANDOM: res[i] = (i <= 30) ? ($urandom_range(0, 3) != 0) : (i == 31);
                M_ONES:   res[i] = 1'b1;
                default:  res[i] = (i <= PRE);
            endcase
            pathResult = res[i];
            start = mid_start && (i == 2);
            @(negedge clk);
            o_pi[i] = pathInput;  o_ld[i] = ld_reg;  o_fin[i] = fin;
            o_busy[i] = busy;     o_err[i] = err;    o_lat[i] = lat_cnt;
            @(posedge clk);
            #1;
        end
        start = 1'b0;

        p = BIG;
        for (int i = PRE; i <= NC; i++) if (res[i] && p == BIG) p = i;
        k = BIG;
        if (p != BIG)
            for (int j = 0; p + 1 + j <= NC; j++) if (!res[p+1+j] && k == BIG) k = j;
        if (TMO_ON && p > TMO) begin
            p = TMO; ld_c = BIG; done_from = TMO + 1; err_run = 1'b1; lat_cap = 0;
        end else if (TMO_ON && k >= TMO) begin
            ld_c = BIG; done_from = p + TMO + 1; err_run = 1'b1; lat_cap = TMO;
        end else begin
            ld_c = p + k + 2; done_from = p + k + 3; err_run = 1'b0; lat_cap = k;
        end

        for (int i = 1; i <= NC; i++) begin
            e_pi   = (i <= p);
            e_ld   = (i == ld_c);
            e_fin  = (i >= done_from);
            e_busy = (i < done_from);
            e_err  = err_run && (i >= done_from);
            e_lat  = (i - p - 1 < 0) ? 0 : i - p - 1;
            if (e_lat > lat_cap) e_lat = lat_cap;
            if (e_lat > 255) e_lat = 255;
            if (o_pi[i] !== e_pi)
                $display("FAIL %s cyc%0d pathInput got %b exp %b", name, i, o_pi[i], e_pi);
            else passed++;
            if (o_ld[i] !== e_ld)
                $display("FAIL %s cyc%0d ld_reg got %b exp %b", name, i, o_ld[i], e_ld);
            else passed++;
            if (o_fin[i] !== e_fin)
                $display("FAIL %s cyc%0d fin got %b exp %b", name, i, o_fin[i], e_fin);
            else passed++;
            if (o_busy[i] !== e_busy)
                $display("FAIL %s cyc%0d busy got %b exp %b", name, i, o_busy[i], e_busy);
            else passed++;
            if (o_err[i] !== e_err)
                $display("FAIL %s cyc%0d err got %b exp %b", name, i, o_err[i], e_err);
            else passed++;
            if (o_lat[i] !== 8'(e_lat))
                $display("FAIL %s cyc%0d lat_cnt got %0d exp %0d", name, i, o_lat[i], e_lat);
            else passed++;
            checks += 6;
        end
    endtask

    task automatic test_nominal;
        do_run(M_CLOSED, 3, 1'b0, "nominal");
    endtask

    task automatic test_slow_precharge;
        do_run(M_CLOSED, 9, 1'b0, "slow_prechg");
    endtask

    task automatic test_immediate_fall;
        do_run(M_IMMED, 0, 1'b0, "immediate_fall");
    endtask

    task automatic test_back_to_back;
        do_run(M_CLOSED, 5, 1'b1, "b2b_busy_start");
        for (int r = 0; r < 10; r++) begin
            if ($urandom_range(0, 1) == 0)
                do_run(M_CLOSED, int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)), "b2b_closed");
            else
                do_run(M_RANDOM, 0, 1'($urandom_range(0, 1)), "b2b_random");
        end
    endtask

    task automatic test_reset_mid_run;
        @(posedge clk);
        #1 start = 1'b1; pathResult = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        if (lat_cnt !== 8'd2 || busy !== 1'b1)
            $display("FAIL rst_mid_run pre-reset lat_cnt/busy got %0d/%b exp 2/1", lat_cnt, busy);
        else passed++;
        checks++;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_idle("rst_mid_run", i);
        end
        pathResult = 1'b0;
    endtask

`ifdef HTL_TIMEOUT_EN
    task automatic test_timeout;
        do_run(M_ONES, 0, 1'b0, "timeout");
    endtask
`endif

    initial begin
        test_reset;
        test_nominal;
        test_slow_precharge;
        test_immediate_fall;
        test_back_to_back;
        test_reset_mid_run;
`ifdef HTL_TIMEOUT_EN
        test_timeout;
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
